// File: rtl/note_sequencer.sv
// Note sequencer: steps through a tone table and drives a registered tone word to a sine generator.
// Define NOTE_SEQUENCER_GATE_EN to turn gate off for the last eighth of each step; otherwise gate follows busy.
module note_sequencer #(
    parameter int FREQSIZE  = 16,
    parameter int ADDRSIZE  = 7,
    parameter int TEMPOSIZE = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic [TEMPOSIZE-1:0] tempo,
    input  logic [ADDRSIZE-1:0]  last_idx,
    output logic [ADDRSIZE-1:0]  rom_addr,
    input  logic [FREQSIZE-1:0]  rom_data,
    output logic [FREQSIZE-1:0]  freq,
    output logic                 freq_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 gate
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // FETCH and LOAD take one cycle each, so a step shorter than 3 cycles cannot be honoured.
    localparam logic [TEMPOSIZE-1:0] MIN_TEMPO = TEMPOSIZE'(3);

    logic [1:0]           r_state;
    logic [ADDRSIZE-1:0]  r_rom_addr;
    logic [FREQSIZE-1:0]  r_freq;
    logic                 r_freq_valid;
    logic                 r_done;
    logic [TEMPOSIZE-1:0] r_tempo_l;
    logic [ADDRSIZE-1:0]  r_last_idx_l;
    logic [TEMPOSIZE-1:0] r_count;

    logic [TEMPOSIZE-1:0] w_tempo_clamped;
    logic                 w_busy;
    logic                 w_gate;

    assign w_tempo_clamped = (tempo < MIN_TEMPO) ? MIN_TEMPO : tempo;
    assign w_busy          = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_rom_addr   <= '0;
            r_freq       <= '0;
            r_freq_valid <= 1'b0;
            r_done       <= 1'b0;
            r_tempo_l    <= '0;
            r_last_idx_l <= '0;
            r_count      <= '0;
        end else begin
            // NOTE: non-blocking assignments here; the pulse defaults below are overridden later in the same block.
            r_freq_valid <= 1'b0;
            r_done       <= 1'b0;
            if (w_busy && stop) begin
                r_state <= S_IDLE;
                r_freq  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            r_state      <= S_FETCH;
                            r_tempo_l    <= w_tempo_clamped;
                            r_last_idx_l <= last_idx;
                            r_rom_addr   <= '0;
                        end
                    end
                    S_FETCH: r_state <= S_LOAD;
                    S_LOAD: begin
                        r_state      <= S_HOLD;
                        r_freq       <= rom_data;
                        r_freq_valid <= 1'b1;
                        r_count      <= r_tempo_l - MIN_TEMPO;
                    end
                    S_HOLD: begin
                        if (r_count != '0) begin
                            r_count <= r_count - TEMPOSIZE'(1);
                        end else if (r_rom_addr != r_last_idx_l) begin
                            r_rom_addr <= r_rom_addr + ADDRSIZE'(1);
                            r_state    <= S_FETCH;
                        end else if (loop_en) begin
                            r_rom_addr <= '0;
                            r_state    <= S_FETCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef NOTE_SEQUENCER_GATE_EN
    assign w_gate = (r_state == S_HOLD) && (r_count >= (r_tempo_l >> 3));
`else
    assign w_gate = w_busy;
`endif

    assign rom_addr   = r_rom_addr;
    assign freq       = r_freq;
    assign freq_valid = r_freq_valid;
    assign busy       = w_busy;
    assign done       = r_done;
    assign gate       = w_gate;

endmodule
